// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx -- 8-N-1 UART receiver with 16x oversampling and 3-sample majority
// voting. The received bytes are presented on a valid/ready stream.
//
// Optional feature macro: UART_RX_PARITY_EN
//   If defined, the receiver expects 8-E-1 frames. An even-parity bit follows
//   the data, and the parity_err output is added.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idles high
//   m_data     received byte, held stable while m_valid is high
//   m_valid    m_data holds an unconsumed byte
//   m_ready    downstream accepts the byte when high together with m_valid
//   frame_err  one-cycle pulse when the stop bit samples low
//   overrun    one-cycle pulse when a good byte is dropped because the
//              output is still full
//   busy       high whenever the FSM is not idle
//   parity_err (UART_RX_PARITY_EN only) one-cycle pulse on a parity mismatch
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI      = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
`ifdef UART_RX_PARITY_EN
    ,
    PARITY
`endif
  } state_t;

  state_t state_reg, state_next;

  logic          rx_meta_reg, rx_s_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [SW-1:0] sample_cnt_reg;
  logic          samp_lo_reg, samp_mid_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    m_data_reg;
  logic          m_valid_reg, frame_err_reg, overrun_reg;

  logic tick, at_decide, at_end, maj;
  logic shift_en, deliver, frame_bad;
`ifdef UART_RX_PARITY_EN
  logic parity_bad_reg, parity_err_reg;
  logic par_capture, par_pulse;
`endif

  assign tick      = (tick_cnt_reg == TICK_LAST);
  assign at_decide = tick && (sample_cnt_reg == S_HI);
  assign at_end    = tick && (sample_cnt_reg == S_LAST);
  // The third vote is the live synchronised sample taken at the decision tick.
  assign maj = (samp_lo_reg & samp_mid_reg) | (samp_lo_reg & rx_s_reg) |
               (samp_mid_reg & rx_s_reg);

  always_comb begin
    state_next = state_reg;
    shift_en   = 1'b0;
    deliver    = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_capture = 1'b0;
    par_pulse   = 1'b0;
`endif
    case (state_reg)
      IDLE:  if (!rx_s_reg) state_next = START;
      START: begin
        if (at_decide && maj) state_next = IDLE;  // glitch, not a start bit
        else if (at_end)      state_next = DATA;
      end
      DATA: begin
        shift_en = at_decide;
        if (at_end && bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        par_capture = at_decide;
        if (at_end) state_next = STOP;
      end
`endif
      STOP: begin
        // Decide mid-stop-bit and go idle straight away, so that a start bit
        // that follows with no gap is still caught on its leading edge.
        if (at_decide) begin
`ifdef UART_RX_PARITY_EN
          par_pulse = parity_bad_reg;
`endif
          if (maj) begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            deliver = !parity_bad_reg;
`else
            deliver = 1'b1;
`endif
          end else begin
            frame_bad  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK:   if (rx_s_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rx_meta_reg    <= 1'b1;
      rx_s_reg       <= 1'b1;
      tick_cnt_reg   <= '0;
      sample_cnt_reg <= '0;
      samp_lo_reg    <= 1'b1;
      samp_mid_reg   <= 1'b1;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      m_data_reg     <= '0;
      m_valid_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;

      // The counters are held at zero while idle, so each frame starts
      // counting from the cycle the FSM enters START.
      if (state_reg == IDLE) begin
        tick_cnt_reg   <= '0;
        sample_cnt_reg <= '0;
      end else begin
        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TW'(1);
        if (tick) sample_cnt_reg <= (sample_cnt_reg == S_LAST) ? '0 : sample_cnt_reg + SW'(1);
      end

      if (tick && sample_cnt_reg == S_LO)  samp_lo_reg  <= rx_s_reg;
      if (tick && sample_cnt_reg == S_MID) samp_mid_reg <= rx_s_reg;

      if (state_reg == START)                bit_cnt_reg <= '0;
      else if (state_reg == DATA && at_end)  bit_cnt_reg <= bit_cnt_reg + 3'd1;

      if (shift_en) shift_reg <= {maj, shift_reg[7:1]};  // LSB first

`ifdef UART_RX_PARITY_EN
      // Even parity: the data bits and the parity bit together hold an even number of ones.
      if (par_capture) parity_bad_reg <= ^{shift_reg, maj};
      parity_err_reg <= par_pulse;
`endif

      frame_err_reg <= frame_bad;
      overrun_reg   <= 1'b0;
      if (deliver) begin
        if (m_valid_reg && !m_ready) begin
          overrun_reg <= 1'b1;        // keep the unconsumed byte
        end else begin
          m_data_reg  <= shift_reg;
          m_valid_reg <= 1'b1;
        end
      end else if (m_valid_reg && m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign m_data    = m_data_reg;
  assign m_valid   = m_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an asynchronous 8-N-1 serial line into bytes, presented on a valid/ready stream for the downstream RX FIFO. It sits between the board `rx` pin and the FIFO write port, and is the counterpart to the UART transmitter that drives `tx`. It uses 16x oversampling with 3-sample majority voting, and flags framing errors and output overruns.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bits per second.
- `OVERSAMPLE`, 16: samples per bit. Must be ≥ 8.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial input; idles high.
- `m_data` output 8: received byte; reset 0x00.
- `m_valid` output 1: `m_data` holds an unconsumed byte; reset 0.
- `m_ready` input 1: downstream accepts the byte when high in the same cycle as `m_valid`.
- `frame_err` output 1: one-cycle pulse for a bad stop bit; reset 0.
- `overrun` output 1: one-cycle pulse when a byte is dropped; reset 0.
- `busy` output 1: high whenever the FSM is not in IDLE; reset 0.

## Operation
- **Synchroniser:** `rx` passes through a 2-FF synchroniser. Both flops reset to 1. Only the synchronised signal `rx_s` is used.
- **Tick generator:** `DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE)`, truncated; this is 27 at the defaults.
  - A counter runs from 0 to DIV-1 and emits a one-cycle `tick` at DIV-1.
  - The counter is cleared when the FSM leaves IDLE.
- **Sampling:** a 4-bit sample counter counts ticks within a bit.
  - `rx_s` is captured at sample indices OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (7, 8, 9 at the defaults).
  - The bit value is the majority of the three captures, decided at index 9.
  - The bit ends at index OVERSAMPLE-1.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** when `rx_s` is 0, go to START and clear the tick and sample counters.
  - **START:** if the majority is 1, treat it as a false start and return to IDLE. If 0, go to DATA at the end of the bit.
  - **DATA:** shift in 8 bits, LSB first. A 3-bit bit counter is used. Go to STOP after bit 7 ends.
  - **STOP:** decide at sample index 9.
    - Majority 1: the byte is good; go to IDLE immediately.
    - Majority 0: pulse `frame_err`, discard the byte, and go to BREAK.
  - **BREAK:** wait until `rx_s` is 1, then go to IDLE.
- **Output register:** a good byte loads `m_data` and sets `m_valid`.
  - `m_valid` clears on `m_valid && m_ready`.
  - Good byte arriving while `m_valid && !m_ready`: pulse `overrun`, drop the new byte, keep the old `m_data`.
  - Good byte arriving in the same cycle as `m_valid && m_ready`: load the new byte, `m_valid` stays 1, no overrun.
- **Reset:** `rst` mid-frame returns the FSM to IDLE, clears all counters and outputs, and discards any partial byte.

## Timing
- Bit period is `DIV*OVERSAMPLE` cycles: 432 at the defaults, versus an ideal 434.03 (−0.47 %, within tolerance).
- Start-edge detection latency: 2 cycles of synchroniser plus 1 cycle to enter START.
- `m_valid` rises 1 cycle after the stop-bit decision tick. That tick is about 9.5 bit periods after the start edge: roughly 4104 cycles plus 3 at the defaults.
- `frame_err` and `overrun` are registered and last exactly 1 cycle, in the same cycle that `m_valid` would have risen.
- The FSM returns to IDLE mid-stop-bit. A start bit that immediately follows a stop bit (back-to-back frames) is therefore captured with no gap.
- `m_data` is stable whenever `m_valid` is 1, until the handshake completes.
- Combinational paths: none from `m_ready` to `m_valid` or `m_data`.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - An even-parity bit follows the data bits (8-E-1), and a PARITY state sits between DATA and STOP.
  - A mismatch pulses output `parity_err` (1 bit, reset 0) in the stop-decision cycle and discards the byte.
  - The FSM still checks the stop bit normally.
  - Frame length is 11 bits, so `m_valid` latency is about 10.5 bit periods.
- **Undefined:** frames are 8-N-1, and neither the PARITY state nor the `parity_err` port exists.

## Test plan
- **Single byte:** defaults, `m_ready`=1, drive 0x41 at 115200 baud → `m_data`=0x41 with a one-cycle `m_valid`, and no error pulses.
- **Back-to-back with stall:** 0x42 then 0x55 with no idle gap, `m_ready` held 0 until both frames end → `m_data`=0x42 and one `overrun` pulse. After `m_ready`=1, `m_valid` drops and no 0x55 appears.
- **False start:** `rx` low for 100 cycles, then high → `busy` pulses, the FSM returns to IDLE, and `m_valid`, `frame_err` and `overrun` stay 0.
- **Framing error:** send 0xA5 with the stop bit driven 0 for 2 bit periods → one `frame_err` pulse, no `m_valid`. A following 0x3C is received correctly.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 of 0xFF, then send 0x12 → only 0x12 is delivered.
- **Parity error (`UART_RX_PARITY_EN` defined):** send 0x07 with parity 0 → one `parity_err` pulse, no `m_valid`. Send 0x07 with parity 1 → `m_data`=0x07.
